// File: rtl/riscv_pkg.sv
// Shared decode definitions for the RV32I decode stage: base opcodes,
// the control-bit bundle carried into EX, and operand-usage helpers.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
    logic jalr;
    logic illegal;
  } ctrl_t;

  // Control bits for an opcode; rd_nz suppresses writes to x0.
  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode, input logic rd_nz);
    ctrl_t c;
    c = '{default: 1'b0};
    case (opcode)
      OP_R, OP_IMM, OP_LUI, OP_AUIPC: c.regwrite = rd_nz;
      OP_LOAD: begin
        c.regwrite = rd_nz;
        c.memread  = 1'b1;
      end
      OP_STORE:  c.memwrite = 1'b1;
      OP_BRANCH: c.branch   = 1'b1;
      OP_JAL: begin
        c.regwrite = rd_nz;
        c.jump     = 1'b1;
      end
      OP_JALR: begin
        c.regwrite = rd_nz;
        c.jump     = 1'b1;
        c.jalr     = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Formats that read rs1: R, I (ALU, load, JALR), S, B.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    logic u;
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH: u = 1'b1;
      default: u = 1'b0;
    endcase
    return u;
  endfunction

  // Formats that read rs2: R, S, B.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    logic u;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: u = 1'b1;
      default: u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/id_stage_pipe_imm_gen.sv
// Immediate generator: assembles the format-specific immediate as a 32-bit
// signed value, then sign-extends it to XLEN.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32_s;

  // Select the immediate layout from the opcode; R-type and unknown give zero.
  always_comb begin
    imm32_s = 32'h0000_0000;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        imm32_s = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32_s = {instr[31:12], 12'h000};
      OP_JAL:
        imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm32_s = 32'h0000_0000;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign imm = {{(XLEN-32){imm32_s[31]}}, imm32_s};
    end else begin : g_narrow
      assign imm = imm32_s[XLEN-1:0];
    end
  endgenerate

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with ID/EX pipeline register. Handles EX back-pressure,
// load-use interlock (bubble insertion with a saturating counter) and flush.
module id_stage_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_IDX_W   = 5,
  parameter bit HAZARD_EN   = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid,
  input  logic [XLEN-1:0]        if_pc,
  input  logic [31:0]            if_instr,
  output logic                   id_ready,
  input  logic                   flush,
  output logic [REG_IDX_W-1:0]   rs1_idx,
  output logic [REG_IDX_W-1:0]   rs2_idx,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic                   ex_ready,
  input  logic [REG_IDX_W-1:0]   ex_rd,
  input  logic                   ex_memread,
  output logic                   id_valid,
  output logic [XLEN-1:0]        id_pc,
  output logic [XLEN-1:0]        id_r1,
  output logic [XLEN-1:0]        id_r2,
  output logic [XLEN-1:0]        id_imm,
  output logic [31:0]            id_instr,
  output logic [REG_IDX_W-1:0]   id_rd,
  output logic [REG_IDX_W-1:0]   id_rs1,
  output logic [REG_IDX_W-1:0]   id_rs2,
  output logic [6:0]             id_opcode,
  output logic [2:0]             id_funct3,
  output logic [6:0]             id_funct7,
  output logic                   id_regwrite,
  output logic                   id_memread,
  output logic                   id_memwrite,
  output logic                   id_branch,
  output logic                   id_jump,
  output logic                   id_jalr,
  output logic                   id_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [REG_IDX_W-1:0]   IDX_ZERO = {REG_IDX_W{1'b0}};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX  = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [6:0]           opcode_s;
  logic [REG_IDX_W-1:0] rd_s;
  logic [XLEN-1:0]      imm_s;
  ctrl_t                ctrl_s;
  logic                 advance_s;
  logic                 hazard_s;

  logic                   id_valid_r;
  ctrl_t                  ctrl_r;
  logic [XLEN-1:0]        id_pc_r;
  logic [XLEN-1:0]        id_r1_r;
  logic [XLEN-1:0]        id_r2_r;
  logic [XLEN-1:0]        id_imm_r;
  logic [31:0]            id_instr_r;
  logic [REG_IDX_W-1:0]   id_rd_r;
  logic [REG_IDX_W-1:0]   id_rs1_r;
  logic [REG_IDX_W-1:0]   id_rs2_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  assign opcode_s = if_instr[6:0];
  assign rd_s     = if_instr[7 +: REG_IDX_W];
  assign rs1_idx  = if_instr[15 +: REG_IDX_W];
  assign rs2_idx  = if_instr[20 +: REG_IDX_W];
  assign ctrl_s   = decode_ctrl(opcode_s, rd_s != IDX_ZERO);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr),
    .imm   (imm_s)
  );

  // Handshake and load-use interlock: stall when EX's load targets a source we read.
  always_comb begin
    advance_s = !id_valid_r || ex_ready;
    hazard_s  = 1'b0;
    if (HAZARD_EN && ex_memread && (ex_rd != IDX_ZERO)) begin
      hazard_s = (uses_rs1(opcode_s) && (ex_rd == rs1_idx)) ||
                 (uses_rs2(opcode_s) && (ex_rd == rs2_idx));
    end else begin
      hazard_s = 1'b0;
    end
    id_ready = advance_s && !hazard_s && !flush;
  end

  // ID/EX register: flush beats hold, hold beats bubble, bubble beats load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_r  <= 1'b0;
      ctrl_r      <= '{default: 1'b0};
      id_pc_r     <= {XLEN{1'b0}};
      id_r1_r     <= {XLEN{1'b0}};
      id_r2_r     <= {XLEN{1'b0}};
      id_imm_r    <= {XLEN{1'b0}};
      id_instr_r  <= 32'h0000_0000;
      id_rd_r     <= IDX_ZERO;
      id_rs1_r    <= IDX_ZERO;
      id_rs2_r    <= IDX_ZERO;
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (flush) begin
      id_valid_r <= 1'b0;
      ctrl_r     <= '{default: 1'b0};
    end else if (!advance_s) begin
      id_valid_r <= id_valid_r;
    end else if (if_valid && hazard_s) begin
      id_valid_r <= 1'b0;
      ctrl_r     <= '{default: 1'b0};
      if (stall_cnt_r != CNT_MAX) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end else if (if_valid) begin
      id_valid_r <= 1'b1;
      ctrl_r     <= ctrl_s;
      id_pc_r    <= if_pc;
      id_r1_r    <= rs1_data;
      id_r2_r    <= rs2_data;
      id_imm_r   <= imm_s;
      id_instr_r <= if_instr;
      id_rd_r    <= rd_s;
      id_rs1_r   <= rs1_idx;
      id_rs2_r   <= rs2_idx;
    end else begin
      id_valid_r <= 1'b0;
      ctrl_r     <= '{default: 1'b0};
    end
  end

  assign id_valid    = id_valid_r;
  assign id_pc       = id_pc_r;
  assign id_r1       = id_r1_r;
  assign id_r2       = id_r2_r;
  assign id_imm      = id_imm_r;
  assign id_instr    = id_instr_r;
  assign id_rd       = id_rd_r;
  assign id_rs1      = id_rs1_r;
  assign id_rs2      = id_rs2_r;
  assign id_opcode   = id_instr_r[6:0];
  assign id_funct3   = id_instr_r[14:12];
  assign id_funct7   = id_instr_r[31:25];
  assign id_regwrite = ctrl_r.regwrite;
  assign id_memread  = ctrl_r.memread;
  assign id_memwrite = ctrl_r.memwrite;
  assign id_branch   = ctrl_r.branch;
  assign id_jump     = ctrl_r.jump;
  assign id_jalr     = ctrl_r.jalr;
  assign id_illegal  = ctrl_r.illegal;
  assign stall_cnt   = stall_cnt_r;

endmodule
